// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver, 5..9 data bits, optional parity, 1/2 stop bits.
// Optional build macro UART_RX_MAJORITY_EN: 3-tick majority vote on every bit sample.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                 system_clk,
   input  logic                 rst,
   input  logic                 os_tick,
   input  logic                 rx_data,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 out_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy,
   output logic [2:0]           flag_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] C_MID = OSW'(OVERSAMPLE/2-1);
   localparam logic [OSW-1:0] C_END = OSW'(OVERSAMPLE-1);
   localparam logic [3:0] C_DLAST = 4'(DATA_BITS-1);
   localparam logic [3:0] C_SLAST = 4'(STOP_BITS-1);

   state_t               r_state;
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_rxs_prev;
   logic [OSW-1:0]       r_os_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_en;
   logic                 r_par_odd;
   logic                 r_perr_pend;
   logic                 r_ferr_pend;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_out_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_overrun;

   logic w_rxs;
   logic w_sample;
   logic w_fall;
   logic w_wrap;
   logic w_samp_tick;
   logic w_complete;
   logic w_accept;
   logic w_perr_now;
   logic w_ferr_now;

   assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] r_hist;

   // Keep rxs from the two previous os_ticks for the majority vote
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         r_hist <= 2'b11;
      end else if (os_tick) begin
         r_hist <= {r_hist[0], w_rxs};
      end
   end

   assign w_sample = (r_hist[1] & r_hist[0]) |
                     (r_hist[1] & w_rxs) |
                     (r_hist[0] & w_rxs);
`else
   assign w_sample = w_rxs;
`endif

   assign w_fall = r_rxs_prev & ~w_rxs;
   assign w_wrap = (r_state == S_START) ? (r_os_cnt == C_MID)
                                        : (r_os_cnt == C_END);
   assign w_samp_tick = os_tick & w_wrap & (r_state != S_IDLE);
   assign w_complete = w_samp_tick & (r_state == S_STOP) &
                       (r_bit_cnt == C_SLAST);
   assign w_accept = ~r_out_valid | out_ready;
   assign w_perr_now = (^r_shift) ^ w_sample ^ r_par_odd;
   assign w_ferr_now = r_ferr_pend | ~w_sample;

   // Two-flop synchroniser plus previous value for start-edge detection
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_rxs_prev <= 1'b1;
      end else begin
         r_sync1    <= rx_data;
         r_sync2    <= r_sync1;
         r_rxs_prev <= r_sync2;
      end
   end

   // Frame FSM: bit timing, data shift, parity and stop checking
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_os_cnt    <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_perr_pend <= 1'b0;
         r_ferr_pend <= 1'b0;
      end else begin
         if (r_state != S_IDLE && os_tick) begin
            r_os_cnt <= w_wrap ? '0 : r_os_cnt + OSW'(1);
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state     <= S_START;
                  r_os_cnt    <= '0;
                  r_bit_cnt   <= '0;
                  r_par_en    <= parity_en;
                  r_par_odd   <= parity_odd;
                  r_perr_pend <= 1'b0;
                  r_ferr_pend <= 1'b0;
               end
            end
            S_START: begin
               if (w_samp_tick) begin
                  r_state <= w_sample ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (w_samp_tick) begin
                  r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == C_DLAST) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_samp_tick) begin
                  r_perr_pend <= w_perr_now;
                  r_state     <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_samp_tick) begin
                  if (!w_sample) r_ferr_pend <= 1'b1;
                  if (r_bit_cnt == C_SLAST) begin
                     r_bit_cnt <= '0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output holding register with valid/ready handshake and overrun pulse
   always_ff @(posedge system_clk or posedge rst) begin
      if (rst) begin
         r_data_out  <= '0;
         r_out_valid <= 1'b0;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_complete && w_accept) begin
            r_data_out  <= r_shift;
            r_perr      <= r_perr_pend;
            r_ferr      <= w_ferr_now;
            r_out_valid <= 1'b1;
         end else if (w_complete) begin
            r_overrun <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign data_out   = r_data_out;
   assign out_valid  = r_out_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign overrun    = r_overrun;
   assign busy       = (r_state != S_IDLE);
   assign flag_state = r_state;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param (1-stop and 2-stop instances).
// Serial frames are driven window by window, one window per os_tick.
`timescale 1ns/1ps
module tb_uart_rx_param;

   logic       clk;
   logic       rst;
   logic       os_tick;
   logic       rx1;
   logic       rx2;
   logic       parity_en;
   logic       parity_odd;
   logic       out_ready;

   logic [7:0] data_out;
   logic       out_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [2:0] flag_state;

   logic [7:0] data_out2;
   logic       out_valid2;
   logic       parity_err2;
   logic       frame_err2;
   logic       overrun2;
   logic       busy2;
   logic [2:0] flag_state2;

   int checks;
   int failures;
   int vcyc;
   int ovcyc;
   logic [9:0] q1[$];
   logic [9:0] q2[$];

   uart_rx_param #(
      .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)
   ) u_dut (
      .system_clk(clk), .rst(rst), .os_tick(os_tick),
      .rx_data(rx1), .parity_en(parity_en),
      .parity_odd(parity_odd), .out_ready(out_ready),
      .data_out(data_out), .out_valid(out_valid),
      .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy),
      .flag_state(flag_state)
   );

   uart_rx_param #(
      .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(2)
   ) u_dut2 (
      .system_clk(clk), .rst(rst), .os_tick(os_tick),
      .rx_data(rx2), .parity_en(parity_en),
      .parity_odd(parity_odd), .out_ready(out_ready),
      .data_out(data_out2), .out_valid(out_valid2),
      .parity_err(parity_err2), .frame_err(frame_err2),
      .overrun(overrun2), .busy(busy2),
      .flag_state(flag_state2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      os_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 os_tick = 1'b1;
         @(posedge clk);
         #1 os_tick = 1'b0;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (out_valid) vcyc++;
      if (overrun) ovcyc++;
      if (out_valid && out_ready)
         q1.push_back({frame_err, parity_err, data_out});
      if (out_valid2 && out_ready)
         q2.push_back({frame_err2, parity_err2, data_out2});
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick(input int n);
      repeat (n) begin
         @(posedge clk);
         while (os_tick !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic send(input bit sel, input logic [15:0] bits,
                       input int nwin, input int glitch);
      wait_tick(1);
      for (int t = 0; t < nwin; t++) begin
         logic v;
         v = bits[t/16];
         if (t == glitch) v = ~v;
         #1;
         if (sel) rx2 = v;
         else rx1 = v;
         wait_tick(1);
      end
      #1;
   endtask

   task automatic chk_q1(input string tag, input logic [9:0] exp);
      chk({tag, "_count"}, q1.size(), 1);
      if (q1.size() > 0) chk(tag, q1.pop_front(), exp);
      q1.delete();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      vcyc = 0;
      ovcyc = 0;
      rst = 1'b1;
      rx1 = 1'b1;
      rx2 = 1'b1;
      parity_en = 1'b0;
      parity_odd = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data", data_out, 0);
      chk("rst_ctrl", {out_valid, parity_err, frame_err, overrun, busy}, 0);
      chk("rst_state", flag_state, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge clk);

      // 8N1 0xA5
      vcyc = 0;
      send(0, 16'({1'b1, 8'hA5, 1'b0}), 160, -1);
      rx1 = 1'b1;
      wait_tick(4);
      #1;
      chk_q1("a5_word", 10'h0A5);
      chk("a5_vcyc", vcyc, 1);
      chk("a5_valid_low", out_valid, 0);

      // even parity, wrong then right parity bit
      parity_en = 1'b1;
      parity_odd = 1'b0;
      send(0, 16'({1'b1, 1'b1, 8'h3C, 1'b0}), 176, -1);
      wait_tick(4);
      #1;
      chk_q1("par_bad", 10'h13C);
      send(0, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 176, -1);
      wait_tick(4);
      #1;
      chk_q1("par_ok", 10'h03C);
      parity_en = 1'b0;

      // two stop bits, second one low
      send(1, 16'({1'b0, 1'b1, 8'h55, 1'b0}), 192, -1);
      rx2 = 1'b1;
      wait_tick(4);
      #1;
      chk("fe_count", q2.size(), 1);
      if (q2.size() > 0) chk("fe_word", q2.pop_front(), 10'h255);

      // false start
      vcyc = 0;
      wait_tick(1);
      #1 rx1 = 1'b0;
      wait_tick(2);
      #1;
      chk("fs_start", {busy, flag_state}, 4'b1001);
      wait_tick(2);
      #1 rx1 = 1'b1;
      wait_tick(20);
      #1;
      chk("fs_idle", {busy, flag_state}, 0);
      chk("fs_novalid", vcyc + q1.size(), 0);

      // one-tick glitch at the sampling point of data bit 3
      send(0, 16'({1'b1, 8'hFF, 1'b0}), 160, 71);
      wait_tick(4);
      #1;
`ifdef UART_RX_MAJORITY_EN
      chk_q1("glitch", 10'h0FF);
`else
      chk_q1("glitch", 10'h0F7);
`endif

      // overrun: 0x11 held, 0x22 dropped
      out_ready = 1'b0;
      ovcyc = 0;
      send(0, 16'({1'b1, 8'h11, 1'b0}), 160, -1);
      send(0, 16'({1'b1, 8'h22, 1'b0}), 160, -1);
      wait_tick(2);
      #1;
      chk("ovr_held", {out_valid, data_out}, 9'h111);
      chk("ovr_pulse", ovcyc, 1);
      chk("ovr_noxfer", q1.size(), 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_drain_valid", out_valid, 0);
      chk_q1("ovr_drain", 10'h011);

      // reset in the middle of data bit 4 with a word held
      out_ready = 1'b0;
      send(0, 16'({1'b1, 8'h42, 1'b0}), 160, -1);
      wait_tick(2);
      #1;
      chk("pre_rst_held", {out_valid, data_out}, 9'h142);
      send(0, 16'({1'b1, 8'h99, 1'b0}), 88, -1);
      chk("pre_rst_state", flag_state, 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {data_out, out_valid, parity_err, frame_err,
                           overrun, busy, flag_state}, 0);
      rx1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      wait_tick(4);
      #1;
      q1.delete();
      send(0, 16'({1'b1, 8'h81, 1'b0}), 160, -1);
      wait_tick(4);
      #1;
      chk_q1("after_rst", 10'h081);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver that replaces the fixed 8N1 receiver in the UART protocol path. It times bits internally from a single oversample tick, supports configurable data width, optional runtime-selected parity and 1 or 2 stop bits, and reports parity, framing and overrun errors. Received words leave through a valid/ready handshake, so a downstream FIFO or consumer can apply backpressure.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
OVERSAMPLE, 16, os_tick pulses per bit period; even, at least 8
STOP_BITS, 1, stop bits checked per frame; 1 or 2

Ports:
system_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
os_tick  in  1  one-cycle strobe at OVERSAMPLE x baud rate
rx_data  in  1  serial line, asynchronous, idle high
parity_en  in  1  1 = frame carries a parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
out_ready  in  1  consumer can accept a word
data_out  out  DATA_BITS  received word, LSB received first
out_valid  out  1  data_out and the error flags are valid
parity_err  out  1  parity mismatch for the word held in data_out
frame_err  out  1  a stop bit sampled 0 for the held word
overrun  out  1  one-cycle pulse when a completed frame is dropped
busy  out  1  high in every state except IDLE
flag_state  out  3  current state encoding, for debug

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Synchroniser flops reset to 1. Reset mid-frame aborts the frame and drops any held word.
- rx_data passes through a 2-flop synchroniser; all logic uses the synchronised value (rxs).
- os_cnt has width clog2(OVERSAMPLE) and advances only on os_tick. bit_cnt counts data and stop bits.
- States and flag_state codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: on rxs falling from 1 to 0, go to START with os_cnt=0. Latch parity_en and parity_odd at this point; they are ignored for the rest of the frame.
- START: on the os_tick where os_cnt==OVERSAMPLE/2-1, sample the line. Sample 1 means a false start: return to IDLE, no output. Sample 0: clear os_cnt, go to DATA.
- Sampling rule for DATA, PARITY and STOP: sample on the os_tick where os_cnt==OVERSAMPLE-1, then wrap os_cnt to 0.
- DATA: shift the sample in from the MSB side, so the first bit received ends up in bit 0. After DATA_BITS samples, go to PARITY if latched parity_en is 1, otherwise to STOP.
- PARITY: the error condition is (XOR of data bits XOR parity bit) != latched parity_odd. Record this as a pending error, then go to STOP.
- STOP: take STOP_BITS samples. Any 0 sample sets the pending frame error. Do not abort early: keep sampling all stop bits.
- Completion: in the cycle after the last stop sample, return to IDLE. A new start edge is accepted from that cycle onward.
- Output handshake:
  - A transfer occurs on any cycle where out_valid and out_ready are both 1.
  - On completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: load data_out, parity_err and frame_err, and set out_valid=1.
  - On completion with out_valid=1 and out_ready=0: keep the held word, discard the new one, pulse overrun for exactly one cycle.
  - out_valid clears after a transfer unless a new word is loaded in that same cycle.
  - data_out and both error flags stay stable while out_valid=1.
- A frame with a framing error is still delivered, with frame_err=1. Break conditions are not detected separately.
- os_tick pulses that arrive while in IDLE are ignored.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample is the majority of rxs captured on the three consecutive os_ticks ending at the sampling tick. For START, those ticks are os_cnt OVERSAMPLE/2-3 .. OVERSAMPLE/2-1; for all other states, OVERSAMPLE-3 .. OVERSAMPLE-1.
- Undefined: a single rxs sample at the sampling tick only.
- Ports and latency are identical with or without the macro.

Test Plan:
- OVERSAMPLE=16, 8N1, send 0xA5, out_ready=1 -> one word, data_out=0xA5, parity_err=0, frame_err=0, out_valid high for 1 cycle.
- parity_en=1, parity_odd=0, send 0x3C with parity bit 1 -> data_out=0x3C, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- STOP_BITS=2, send 0x55 with second stop bit driven 0 -> data_out=0x55, frame_err=1.
- Line pulsed low for 4 os_ticks, then high -> return to IDLE, no out_valid. With the macro defined, a 1-tick glitch at the mid-bit of data bit 3 of 0xFF is rejected -> data_out=0xFF.
- out_ready=0, send 0x11 then 0x22 -> held word 0x11, overrun pulses once. Raise out_ready -> 0x11 delivered, out_valid then drops to 0.
- Assert rst in the middle of data bit 4 -> all outputs 0, FSM in IDLE; the next frame 0x81 is received correctly.
